// File: rtl/ysyx_25060170_rf_sb_if.sv
// ysyx_25060170_rf_sb_if: decode/write-back bundle for the scoreboarded register file
//   master: drives read addresses, write-back and issue request; sees read data, ready, busy
//   slave : the register file side
interface ysyx_25060170_rf_sb_if #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int AW   = 5,
   parameter int NRD  = 2
);
   logic [NRD*AW-1:0]   rd_addr;
   logic [NRD*XLEN-1:0] rd_data;
   logic                wb_en;
   logic [AW-1:0]       wb_addr;
   logic [XLEN-1:0]     wb_data;
   logic                issue_valid;
   logic [AW-1:0]       issue_rd;
   logic                issue_has_rd;
   logic                issue_ready;
   logic [NREG-1:0]     busy;
   modport master (
      output rd_addr, wb_en, wb_addr, wb_data, issue_valid, issue_rd, issue_has_rd,
      input  rd_data, issue_ready, busy
   );
   modport slave (
      input  rd_addr, wb_en, wb_addr, wb_data, issue_valid, issue_rd, issue_has_rd,
      output rd_data, issue_ready, busy
   );
endinterface

// File: rtl/ysyx_25060170_rf_sb.sv
// ysyx_25060170_rf_sb: register file with NRD read ports, one write-back port, optional bypass and busy scoreboard
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of ysyx_25060170_rf_sb_if (read ports, write-back, issue handshake, busy vector)
module ysyx_25060170_rf_sb #(
   parameter int              XLEN      = 32,
   parameter int              NREG      = 32,
   parameter int              AW        = 5,
   parameter int              NRD       = 2,
   parameter bit              BYPASS    = 1'b1,
   parameter logic [XLEN-1:0] RESET_VAL = '0
) (
   input logic                   clk,
   input logic                   rst,
   ysyx_25060170_rf_sb_if.slave  bus
);
   logic [XLEN-1:0]     regs [NREG];
   logic [NREG-1:0]     busy_q, busy_d;
   logic [XLEN-1:0]     port_data [NRD];
   logic [NRD-1:0]      src_haz;
   logic [NRD*XLEN-1:0] rd_data;
   logic                wb_act, waw_haz, ready, accept;
   // a write-back is dropped while reset is held and never touches x0,
   // which also keeps it from being forwarded in either case
   assign wb_act = bus.wb_en && !rst && bus.wb_addr != '0;
   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [AW-1:0] a;
      logic          fwd;
      assign a            = bus.rd_addr[k*AW +: AW];
      assign fwd          = BYPASS && wb_act && bus.wb_addr == a;
      assign port_data[k] = a == '0 ? '0 : fwd ? bus.wb_data : regs[a];
      assign src_haz[k]   = a != '0 && busy_q[a] && !fwd;
   end
   always_comb begin
      rd_data = '0;
      for (int k = 0; k < NRD; k++) rd_data[k*XLEN +: XLEN] = port_data[k];
   end
   // a write-back retiring the destination this cycle resolves WAW even without bypass
   assign waw_haz = bus.issue_has_rd && busy_q[bus.issue_rd] && !(wb_act && bus.wb_addr == bus.issue_rd);
   assign ready   = !(|src_haz) && !waw_haz;
   assign accept  = bus.issue_valid && ready && bus.issue_has_rd && bus.issue_rd != '0;
   // clear first so that an issue to the same register wins
   always_comb begin
      busy_d = busy_q;
      if (wb_act) busy_d[bus.wb_addr] = 1'b0;
      if (accept) busy_d[bus.issue_rd] = 1'b1;
      busy_d[0] = 1'b0;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) busy_q <= '0;
      else     busy_q <= busy_d;
   always_ff @(posedge clk or posedge rst)
      if (rst)
         for (int i = 0; i < NREG; i++) regs[i] <= i == 0 ? '0 : RESET_VAL;
      else if (wb_act)
         regs[bus.wb_addr] <= bus.wb_data;
   assign bus.rd_data     = rd_data;
   assign bus.issue_ready = ready;
   assign bus.busy        = busy_q;
endmodule

// File: tb/tb_ysyx_25060170_rf_sb.sv
// tb_ysyx_25060170_rf_sb: random and directed checks of the register file against a behavioural model
module tb_ysyx_25060170_rf_sb;
   localparam int NREG = 32;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;
   // shared stimulus for the bypass (a) and no-bypass (b) instances
   logic [4:0]  ra [2];
   logic        wb_en, iv, ihas;
   logic [4:0]  wb_addr, ird;
   logic [31:0] wb_data;
   int total = 0;
   int bad = 0;
   // model state: index 0 follows dut_a (bypass), index 1 follows dut_b
   logic [31:0]     m_regs [2][NREG];
   logic [NREG-1:0] m_busy [2];
   ysyx_25060170_rf_sb_if #(.XLEN(32), .NREG(32), .AW(5), .NRD(2)) ia ();
   ysyx_25060170_rf_sb_if #(.XLEN(32), .NREG(32), .AW(5), .NRD(2)) ib ();
   ysyx_25060170_rf_sb_if #(.XLEN(32), .NREG(16), .AW(4), .NRD(3)) ic ();
   ysyx_25060170_rf_sb #(.BYPASS(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(ia));
   ysyx_25060170_rf_sb #(.BYPASS(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(ib));
   ysyx_25060170_rf_sb #(.NREG(16), .AW(4), .NRD(3), .BYPASS(1'b1), .RESET_VAL(32'h0000_1111))
      dut_c (.clk(clk), .rst(rst), .bus(ic));
   assign ia.rd_addr = {ra[1], ra[0]};
   assign ib.rd_addr = {ra[1], ra[0]};
   assign ia.wb_en = wb_en;
   assign ib.wb_en = wb_en;
   assign ia.wb_addr = wb_addr;
   assign ib.wb_addr = wb_addr;
   assign ia.wb_data = wb_data;
   assign ib.wb_data = wb_data;
   assign ia.issue_valid = iv;
   assign ib.issue_valid = iv;
   assign ia.issue_rd = ird;
   assign ib.issue_rd = ird;
   assign ia.issue_has_rd = ihas;
   assign ib.issue_has_rd = ihas;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   function automatic logic [31:0] m_read(input int m, input logic [4:0] a);
      if (a == 0) return 32'h0;
      if (m == 0 && wb_en && wb_addr == a) return wb_data;
      return m_regs[m][a];
   endfunction
   function automatic logic m_ready(input int m);
      for (int k = 0; k < 2; k++)
         if (ra[k] != 0 && m_busy[m][ra[k]] && !(m == 0 && wb_en && wb_addr == ra[k])) return 1'b0;
      if (ihas && m_busy[m][ird] && !(wb_en && wb_addr == ird)) return 1'b0;
      return 1'b1;
   endfunction
   task automatic check_all();
      chk("a_rd0", ia.rd_data[31:0], m_read(0, ra[0]));
      chk("a_rd1", ia.rd_data[63:32], m_read(0, ra[1]));
      chk("a_ready", ia.issue_ready, m_ready(0));
      chk("a_busy", ia.busy, m_busy[0]);
      chk("b_rd0", ib.rd_data[31:0], m_read(1, ra[0]));
      chk("b_rd1", ib.rd_data[63:32], m_read(1, ra[1]));
      chk("b_ready", ib.issue_ready, m_ready(1));
      chk("b_busy", ib.busy, m_busy[1]);
   endtask
   task automatic drive(input logic [4:0] r0, input logic [4:0] r1, input logic we, input logic [4:0] wa,
                        input logic [31:0] wd, input logic v, input logic [4:0] rd, input logic h);
      ra[0] = r0; ra[1] = r1; wb_en = we; wb_addr = wa; wb_data = wd; iv = v; ird = rd; ihas = h;
      #1;
      check_all();
   endtask
   task automatic tick();
      logic acc [2];
      for (int m = 0; m < 2; m++) acc[m] = iv && m_ready(m) && ihas && ird != 0;
      @(posedge clk);
      for (int m = 0; m < 2; m++) begin
         if (wb_en && wb_addr != 0) begin
            m_regs[m][wb_addr] = wb_data;
            m_busy[m][wb_addr] = 1'b0;
         end
         if (acc[m]) m_busy[m][ird] = 1'b1;
      end
      @(negedge clk);
   endtask
   // reset asserted mid-cycle with a write-back pending: it must be dropped
   task automatic do_reset();
      ra[0] = 5; ra[1] = 0; wb_en = 1; wb_addr = 5; wb_data = 32'hDEAD_BEEF; iv = 1; ird = 3; ihas = 1;
      ic.rd_addr = {4'd0, 4'd5, 4'd1};
      #2 rst = 1'b1;
      #1;
      chk("rst_a_busy", ia.busy, 0);
      chk("rst_a_ready", ia.issue_ready, 1);
      chk("rst_a_rd", ia.rd_data[31:0], 0);
      chk("rst_b_busy", ib.busy, 0);
      chk("rst_b_ready", ib.issue_ready, 1);
      chk("rst_c_busy", ic.busy, 0);
      chk("rst_c_ready", ic.issue_ready, 1);
      chk("rst_c_rd0", ic.rd_data[31:0], 32'h1111);
      chk("rst_c_rd2", ic.rd_data[95:64], 0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      wb_en = 0; iv = 0;
      for (int m = 0; m < 2; m++) begin
         m_busy[m] = '0;
         for (int r = 0; r < NREG; r++) m_regs[m][r] = 32'h0;
      end
   endtask
   initial begin
      ra[0] = 0; ra[1] = 0; wb_en = 0; wb_addr = 0; wb_data = 0; iv = 0; ird = 0; ihas = 0;
      ic.rd_addr = '0; ic.wb_en = 0; ic.wb_addr = 0; ic.wb_data = 0;
      ic.issue_valid = 0; ic.issue_rd = 0; ic.issue_has_rd = 0;
      @(negedge clk);
      do_reset();
      // build busy = 0x6, then reset mid-run
      drive(0, 0, 0, 0, 0, 1, 1, 1); tick();
      drive(0, 0, 0, 0, 0, 1, 2, 1); tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      chk("busy6", ia.busy, 32'h6);
      do_reset();
      drive(5, 0, 0, 0, 0, 0, 0, 0);
      chk("x5_after_rst", ia.rd_data[31:0], 0);
      drive(0, 0, 1, 0, 32'hDEAD_BEEF, 0, 0, 0); tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      chk("x0_read", ia.rd_data[31:0], 0);
      // bypass latency
      drive(3, 0, 1, 3, 32'h1234_5678, 0, 0, 0);
      chk("byp_same", ia.rd_data[31:0], 32'h1234_5678);
      chk("nobyp_old", ib.rd_data[31:0], 0);
      tick();
      drive(3, 3, 0, 0, 0, 0, 0, 0);
      chk("nobyp_next", ib.rd_data[31:0], 32'h1234_5678);
      chk("dup_port", ia.rd_data[63:32], 32'h1234_5678);
      // RAW
      drive(0, 0, 0, 0, 0, 1, 7, 1); tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      chk("raw_busy7", ia.busy[7], 1);
      drive(7, 0, 0, 0, 0, 1, 8, 1);
      chk("raw_stall", ia.issue_ready, 0);
      tick();
      drive(7, 0, 1, 7, 32'hA5, 1, 8, 1);
      chk("raw_byp_ready", ia.issue_ready, 1);
      chk("raw_byp_data", ia.rd_data[31:0], 32'hA5);
      chk("raw_nobyp_ready", ib.issue_ready, 0);
      tick();
      // WAW
      drive(0, 0, 0, 0, 0, 1, 9, 1); tick();
      drive(0, 0, 0, 0, 0, 1, 9, 1);
      chk("waw_stall", ia.issue_ready, 0);
      drive(0, 0, 1, 9, 32'hCAFE_0009, 1, 9, 1);
      chk("waw_clear_a", ia.issue_ready, 1);
      chk("waw_clear_b", ib.issue_ready, 1);
      tick();
      drive(9, 0, 0, 0, 0, 0, 0, 0);
      chk("waw_set_wins", ia.busy[9], 1);
      chk("waw_data", ia.rd_data[31:0], 32'hCAFE_0009);
      // x0 destination and no-destination issues
      drive(0, 0, 0, 0, 0, 1, 0, 1);
      chk("x0_issue_ready", ia.issue_ready, 1);
      tick();
      drive(0, 0, 0, 0, 0, 1, 12, 0);
      chk("x0_not_busy", ia.busy[0], 0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      chk("no_rd_not_busy", ia.busy[12], 0);
      // random traffic, with one reset in the middle
      for (int i = 0; i < 400; i++) begin
         if (i == 200) do_reset();
         drive(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom_range(0, 9) < 4,
               5'($urandom_range(0, 7)), $urandom, $urandom_range(0, 9) < 7,
               5'($urandom_range(0, 7)), $urandom_range(0, 9) < 8);
         tick();
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      // three-port, 16-register instance
      ic.wb_en = 1; ic.wb_addr = 4; ic.wb_data = 32'h55; ic.rd_addr = {4'd4, 4'd4, 4'd4};
      @(posedge clk); @(negedge clk);
      ic.wb_en = 0;
      #1;
      chk("c_p0", ic.rd_data[31:0], 32'h55);
      chk("c_p1", ic.rd_data[63:32], 32'h55);
      chk("c_p2", ic.rd_data[95:64], 32'h55);
      ic.rd_addr = {4'd1, 4'd0, 4'd4};
      #1;
      chk("c_resetval", ic.rd_data[95:64], 32'h1111);
      chk("c_x0", ic.rd_data[63:32], 0);
      ic.issue_valid = 1; ic.issue_rd = 6; ic.issue_has_rd = 1;
      @(posedge clk); @(negedge clk);
      ic.issue_valid = 0; ic.issue_has_rd = 0;
      ic.rd_addr = {4'd6, 4'd4, 4'd4};
      #1;
      chk("c_busy", ic.busy, 16'h0040);
      chk("c_haz_p2", ic.issue_ready, 0);
      ic.rd_addr = {4'd0, 4'd4, 4'd4};
      #1;
      chk("c_no_haz", ic.issue_ready, 1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/ysyx_25060170_rf_sb.md
Name: ysyx_25060170_rf_sb

Overview:
Parametrised successor to the IDU's inline register array: a general-purpose register file with NRD combinational read ports, one write-back port, optional write-to-read bypass, and a per-register busy scoreboard. Sits between decode (read addresses, issue requests) and write-back (WBU/LSU results). Gates instruction issue on RAW and WAW hazards, so the core can run multi-cycle execute units without corrupting operands.

Parameters:
XLEN, 32, register data width in bits
NREG, 32, number of architectural registers; power of two, ≥2; register 0 hardwired to zero
AW, 5, address width = log2(NREG)
NRD, 2, number of read ports (1..4)
BYPASS, 1, 1 = same-cycle write-back data forwarded to read ports and hazard check; 0 = no forwarding
RESET_VAL, 0, value loaded into registers 1..NREG-1 on reset

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous active-high reset
rd_addr_i  in  NRD*AW  read addresses; port k uses bits [k*AW +: AW]
rd_data_o  out  NRD*XLEN  read data; port k uses bits [k*XLEN +: XLEN]; combinational
wb_en_i  in  1  write-back enable
wb_addr_i  in  AW  write-back register address
wb_data_i  in  XLEN  write-back data
issue_valid_i  in  1  decode requests issue of an instruction whose sources are rd_addr_i
issue_rd_i  in  AW  destination register of the issuing instruction
issue_has_rd_i  in  1  1 = the instruction writes issue_rd_i
issue_ready_o  out  1  no hazard; issue accepted when issue_valid_i & issue_ready_o
busy_o  out  NREG  scoreboard bit vector; bit 0 is always 0

Behaviour:
- Reset (async assert, sync release on clk):
  - regs[1..NREG-1] = RESET_VAL; busy = 0.
  - Outputs during reset: issue_ready_o = 1, busy_o = 0.
  - rd_data_o = RESET_VAL for nonzero addresses and 0 for address 0.
  - Reset mid-operation discards all pending busy bits; a write-back arriving in the same cycle is ignored.
- Register 0:
  - Writes are ignored.
  - Reads return 0.
  - Never marked busy; issue with issue_rd_i = 0 sets nothing.
- Write: on posedge, when wb_en_i and wb_addr_i != 0: regs[wb_addr_i] <= wb_data_i; busy[wb_addr_i] <= 0.
- Read port k (combinational):
  - addr 0 returns 0.
  - Else, if BYPASS and wb_en_i and wb_addr_i == addr, returns wb_data_i.
  - Else returns regs[addr].
  - Bypass never applies to address 0.
- Hazards:
  - src_haz_k = busy[rd_addr_k] and not (BYPASS and wb_en_i and wb_addr_i == rd_addr_k). Only ports whose address is nonzero count.
  - waw_haz = issue_has_rd_i and busy[issue_rd_i] and not (wb_en_i and wb_addr_i == issue_rd_i). The WAW clear by a same-cycle write-back applies regardless of BYPASS.
  - issue_ready_o = no src_haz_k on any port and no waw_haz. Purely combinational; it does not depend on issue_valid_i.
- Issue accept: on posedge, when issue_valid_i and issue_ready_o and issue_has_rd_i and issue_rd_i != 0, busy[issue_rd_i] <= 1.
- Simultaneous write-back clear and issue set on the same register: the set wins, so busy = 1 next cycle. The register data still takes wb_data_i.
- Latency:
  - Write visible on the read port the next cycle, or the same cycle with BYPASS = 1.
  - Busy set visible on busy_o the next cycle.
- Write-back to a non-busy register is legal: the data is written and busy stays 0.
- Several read ports may address the same register; each returns identical data.

Test Plan:
- Reset and zero register: assert rst mid-run with busy_o = 0x0000_0006 → busy_o = 0 and issue_ready_o = 1 immediately. After release, reading x5 gives 0. wb x0 = 0xDEAD_BEEF, then read x0 → 0.
- Write/read latency with BYPASS = 1: wb x3 = 0x1234_5678 with rd_addr port0 = 3 in the same cycle → rd_data port0 = 0x1234_5678 that cycle. With BYPASS = 0 → old value that cycle, new value the next cycle.
- RAW stall: issue rd = x7 accepted → busy_o[7] = 1 next cycle. Next instruction with source x7 → issue_ready_o = 0. wb x7 = 0xA5 with BYPASS = 1 → issue_ready_o = 1 that cycle and rd_data = 0xA5.
- WAW: x9 busy; issue with issue_rd_i = 9 → ready = 0. Same cycle with wb x9 → ready = 1; after accept, busy_o[9] = 1 (set beats clear) and regs[9] = wb data.
- Issue with rd = x0 and issue_has_rd_i = 1 → accepted, busy_o stays 0. Issue with issue_has_rd_i = 0 → no busy bit set.
- NRD = 3, NREG = 16 build: all three ports read x4 = 0x55 simultaneously → all return 0x55. A hazard on port 2 only (x6 busy) → issue_ready_o = 0.
